// File: rtl/pattern_scanner_pkg.sv
// Shared types and helpers for the pattern scanner: FSM state encoding and
// the width of the fill counter that tracks beats collected since the last flush.
package pattern_scanner_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_e;

    // One extra bit so the counter can represent DEPTH-1 for any legal DEPTH.
    function automatic int fill_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pattern_scanner_sym_shreg.sv
// Symbol history shift register; element 0 is the newest symbol, element
// DEPTH-1 the oldest. Advances only on shift beats, flush zeroes it.
module sym_shreg
    import pattern_scanner_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_shift,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DEPTH*DATA_W-1:0] o_history
);

    logic [DEPTH-1:0][DATA_W-1:0] hist_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            hist_q <= '0;
        end else if (i_shift) begin
            hist_q <= {hist_q[DEPTH-2:0], i_data};
        end
    end

    assign o_history = hist_q;

endmodule

// File: rtl/pattern_scanner.sv
// Streaming masked pattern detector: compares the last DEPTH valid symbols
// against a runtime pattern and reports registered match pulses plus a count.
module pattern_scanner
    import pattern_scanner_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter bit OVERLAP = 1'b1,
    parameter int COUNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [DATA_W-1:0]       i_data,
    input  logic [DEPTH*DATA_W-1:0] i_pattern,
    input  logic [DEPTH*DATA_W-1:0] i_mask,
    input  logic                    i_clear,
    output logic                    o_detected,
    output logic [COUNT_W-1:0]      o_count
);

    localparam int PAT_W  = DEPTH * DATA_W;
    localparam int FILL_W = fill_cnt_w(DEPTH);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(DEPTH - 1);

    logic [PAT_W-1:0]   hist;
    logic [PAT_W-1:0]   window;
    logic               match;
    logic               eligible;
    logic               hit;
    logic               unused_oldest;

    state_e             state_q;
    logic [FILL_W-1:0]  fill_q;
    logic               det_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    sym_shreg #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_hist (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (i_clear),
        .i_shift   (i_valid),
        .i_data    (i_data),
        .o_history (hist)
    );

    // The oldest stored symbol is about to fall out; the completing beat replaces it.
    assign window        = {hist[PAT_W-DATA_W-1:0], i_data};
    assign unused_oldest = ^hist[PAT_W-1:PAT_W-DATA_W];

    assign match    = ((window ^ i_pattern) & i_mask) == '0;
    assign eligible = i_valid && !i_clear && ((state_q == ARMED) || (fill_q == LAST_FILL));
    assign hit      = eligible && match;

    assign count_d = (count_q == '1) ? count_q : count_q + COUNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            state_q <= FILL;
            fill_q  <= '0;
            det_q   <= 1'b0;
            count_q <= '0;
        end else begin
            det_q <= hit;
            if (hit) begin
                count_q <= count_d;
            end
            if (i_valid) begin
                case (state_q)
                    FILL: begin
                        if (fill_q == LAST_FILL) begin
                            fill_q  <= '0;
                            state_q <= (hit && !OVERLAP) ? FILL : ARMED;
                        end else begin
                            fill_q <= fill_q + FILL_W'(1);
                        end
                    end
                    ARMED: begin
                        // Non-overlapping mode demands a completely fresh window.
                        if (hit && !OVERLAP) begin
                            state_q <= FILL;
                            fill_q  <= '0;
                        end
                    end
                    default: begin
                        state_q <= FILL;
                        fill_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_detected = det_q;
    assign o_count    = count_q;

endmodule

// File: tb/tb_pattern_scanner.sv
// Drives an overlapping and a non-overlapping scanner with identical stimulus
// and checks both against a queue-based model of the last DEPTH valid symbols.
module tb_pattern_scanner;

    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst, valid, clear;
    logic [DW-1:0] data;
    logic [31:0]   pat, msk;
    logic          det_a, det_b;
    logic [15:0]   cnt_a;
    logic [3:0]    cnt_b;

    int compared   = 0;
    int mismatched = 0;
    int qa[$];
    int qb[$];
    int ca, cb, pulses_a, pulses_b;
    bit ea, eb;

    always #5 clk = ~clk;

    pattern_scanner #(.DATA_W(DW), .DEPTH(D), .OVERLAP(1'b1), .COUNT_W(16)) u_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_pattern(pat),
        .i_mask(msk), .i_clear(clear), .o_detected(det_a), .o_count(cnt_a)
    );

    pattern_scanner #(.DATA_W(DW), .DEPTH(D), .OVERLAP(1'b0), .COUNT_W(4)) u_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_pattern(pat),
        .i_mask(msk), .i_clear(clear), .o_detected(det_b), .o_count(cnt_b)
    );

    // Symbol k of the window (0 = oldest) against the pattern/mask slice of the same age.
    function automatic bit win_hit(input int q[$], input logic [31:0] p, input logic [31:0] m);
        logic [31:0] ps, ms;
        for (int k = 0; k < D; k++) begin
            ps = (p >> (8 * (D - 1 - k))) & 32'hFF;
            ms = (m >> (8 * (D - 1 - k))) & 32'hFF;
            if (((q[k] ^ ps) & ms) != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit c, input bit r);
        @(negedge clk);
        valid = v; data = d; clear = c; rst = r;
        if (r || c) begin
            qa.delete(); qb.delete();
            ca = 0; cb = 0; ea = 1'b0; eb = 1'b0;
        end else if (v) begin
            qa.push_back(int'(d));
            if (qa.size() > D) void'(qa.pop_front());
            qb.push_back(int'(d));
            if (qb.size() > D) void'(qb.pop_front());
            ea = (qa.size() == D) && win_hit(qa, pat, msk);
            eb = (qb.size() == D) && win_hit(qb, pat, msk);
            if (ea && ca < 65535) ca++;
            if (eb && cb < 15) cb++;
            if (eb) qb.delete();
        end else begin
            ea = 1'b0; eb = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("det_a", {15'd0, det_a}, {15'd0, ea});
        chk("cnt_a", cnt_a, ca[15:0]);
        chk("det_b", {15'd0, det_b}, {15'd0, eb});
        chk("cnt_b", {12'd0, cnt_b}, cb[15:0]);
        if (det_a) pulses_a++;
        if (det_b) pulses_b++;
    endtask

    task automatic beat(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; clear = 1'b0; data = '0;
        pat = 32'hABCDEF01; msk = 32'hFFFFFFFF;
        ca = 0; cb = 0; pulses_a = 0; pulses_b = 0;

        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hAB, 1'b1, 1'b1);

        // Basic match, latency one
        beat(8'hAB); beat(8'hCD); beat(8'hEF); beat(8'h01);
        chk("basic_det", {15'd0, det_a}, 16'd1);
        idle();
        chk("basic_cnt", cnt_a, 16'd1);

        // Overlap vs non-overlap on six identical symbols
        step(1'b0, 8'h00, 1'b1, 1'b0);
        pat = 32'hAAAAAAAA; pulses_a = 0; pulses_b = 0;
        repeat (6) beat(8'hAA);
        idle();
        chk("ovl_cnt_a", cnt_a, 16'd3);
        chk("ovl_cnt_b", {12'd0, cnt_b}, 16'd1);
        chk("ovl_pulses_b", pulses_b[15:0], 16'd1);

        // Fill guard on zero history after reset
        step(1'b0, 8'h00, 1'b0, 1'b1);
        pat = 32'h00000000;
        beat(8'h00); beat(8'h00); beat(8'h00);
        chk("fill_guard", cnt_a, 16'd0);
        beat(8'h00);
        chk("fill_fourth", {15'd0, det_a}, 16'd1);

        // Masked nibble with bubbles between beats
        step(1'b0, 8'h00, 1'b1, 1'b0);
        pat = 32'hABCDEF01; msk = 32'hFFFFFFF0;
        beat(8'hAB); idle(); beat(8'hCD); idle(); idle(); idle(); beat(8'hEF); beat(8'h0F);
        chk("mask_det", {15'd0, det_a}, 16'd1);
        msk = 32'hFFFFFFFF;

        // Clear mid-pattern, and clear colliding with a valid beat
        step(1'b0, 8'h00, 1'b1, 1'b0);
        beat(8'hAB); beat(8'hCD);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        beat(8'hEF); beat(8'h01);
        chk("clear_cnt", cnt_a, 16'd0);
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        beat(8'hCD); beat(8'hEF); beat(8'h01);
        chk("clear_drop", cnt_a, 16'd0);

        // Reset mid-pattern discards progress
        beat(8'hAB); beat(8'hCD); beat(8'hEF);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        beat(8'h01);
        chk("rst_mid", {15'd0, det_a}, 16'd0);

        // Saturation of the narrow counter
        step(1'b0, 8'h00, 1'b1, 1'b0);
        pat = 32'hAAAAAAAA; pulses_b = 0;
        repeat (68) beat(8'hAA);
        idle();
        chk("sat_cnt_b", {12'd0, cnt_b}, 16'd15);
        chk("sat_pulses_b", pulses_b[15:0], 16'd17);
        chk("sat_cnt_a", cnt_a, 16'd65);

        // Randomized traffic over a small alphabet so matches are frequent
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            int r;
            logic [7:0] sym;
            r = $urandom_range(0, 99);
            if (n % 250 == 0) begin
                pat = {8'h5A | 8'($urandom_range(0, 1)), 8'h5A, 8'h5A | 8'($urandom_range(0, 1)), 8'h5A};
                msk = ($urandom_range(0, 3) == 0) ? 32'h00000000 : 32'hFFFFFFFE | 32'($urandom_range(0, 1));
            end
            sym = 8'h5A | 8'($urandom_range(0, 1));
            if (r < 1)       step(1'b1, sym, 1'b0, 1'b1);
            else if (r < 3)  step($urandom_range(0, 1) == 1, sym, 1'b1, 1'b0);
            else if (r < 75) beat(sym);
            else             idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
